spo2_ratio_unit: RTL and testbench

Downstream consumer of the LED/PGA controller's per-channel ADC samples once setting search is complete.
- Per channel (RED, IR), accumulates a window of 2^WIN_LOG2 samples and extracts AC (max−min) and DC (mean).
- Computes the ratio-of-ratios R = (AC_red·DC_ir)/(AC_ir·DC_red) as unsigned fixed point, using a sequential divider.
- Result goes to the SpO2 lookup/display stage.

---
 rtl/ppg_pkg.sv | 9 +
 rtl/seq_divider.sv | 73 +++++++
 rtl/spo2_ratio_unit.sv | 200 ++++++++++++++++++++
 tb/tb_spo2_ratio_unit.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ppg_pkg.sv
// ppg_pkg: shared state encoding, datapath widths and divider width derivation for the SpO2 ratio unit
package ppg_pkg;
    typedef enum logic [2:0] {IDLE, ACCUM, MULT, DIVIDE, DONE} state_t;
    localparam int ADC_W  = 8;
    localparam int PROD_W = 16;
    function automatic int num_w(input int frac);
        return PROD_W + frac;
    endfunction
endpackage

// File: rtl/seq_divider.sv
// seq_divider: restoring shift-subtract divider, one quotient bit per clock
// Ports: CLK/rst_n clock and async active-low reset; clr abandons a running divide;
//   start loads num/den (ignored when den is zero); done is high in the final
//   iteration cycle with quot valid combinationally; dbz flags a zero den input.
module seq_divider
    import ppg_pkg::*;
#(
    parameter int NUM_W = 22,
    parameter int DEN_W = PROD_W
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quot,
    output logic             dbz
);
    localparam int CNT_W = $clog2(NUM_W);

    logic [NUM_W-1:0] dvd_q, dvd_d;
    logic [DEN_W-1:0] rem_q, rem_d, den_q, den_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [DEN_W:0]   trial;
    logic             ge;

    // dvd_q shifts dividend bits out of the top while quotient bits enter at the bottom
    always_comb begin
        trial = {rem_q, dvd_q[NUM_W-1]};
        ge    = trial >= {1'b0, den_q};
        quot  = {dvd_q[NUM_W-2:0], ge};
        done  = run_q && (cnt_q == CNT_W'(NUM_W - 1));
        dbz   = (den == '0);
        dvd_d = dvd_q;
        rem_d = rem_q;
        den_d = den_q;
        cnt_d = cnt_q;
        run_d = run_q;
        if (clr) begin
            run_d = 1'b0;
        end else if (start) begin
            run_d = !dbz;
            dvd_d = num;
            rem_d = '0;
            den_d = den;
            cnt_d = '0;
        end else if (run_q) begin
            dvd_d = quot;
            rem_d = DEN_W'(ge ? trial - {1'b0, den_q} : trial);
            cnt_d = cnt_q + CNT_W'(1);
            run_d = !done;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            dvd_q <= '0;
            rem_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            dvd_q <= dvd_d;
            rem_q <= rem_d;
            den_q <= den_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/spo2_ratio_unit.sv
// spo2_ratio_unit: per-window AC/DC extraction of RED/IR PPG samples and ratio-of-ratios R
// Ports: CLK/rst_n clock and async active-low reset; enable runs the unit (low aborts to idle);
//   sample_valid/sample_is_red/sample_data ADC sample stream; AC_RED/AC_IR window max-min;
//   DC_RED/DC_IR window mean; R_ratio Q(8-FRAC).FRAC saturating; ratio_valid one-cycle
//   result strobe; div_err zero denominator; busy while computing a result.
// Build option PPG_PERFUSION_GATE_EN: skips the divide for windows whose AC is below MIN_AC
//   and reports them on the extra low_perf output.
module spo2_ratio_unit
    import ppg_pkg::*;
#(
    parameter int WIN_LOG2 = 5,
    parameter int FRAC     = 6,
    parameter int MIN_AC   = 4
) (
    input  logic             CLK,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sample_valid,
    input  logic             sample_is_red,
    input  logic [ADC_W-1:0] sample_data,
    output logic [ADC_W-1:0] AC_RED,
    output logic [ADC_W-1:0] AC_IR,
    output logic [ADC_W-1:0] DC_RED,
    output logic [ADC_W-1:0] DC_IR,
    output logic [ADC_W-1:0] R_ratio,
    output logic             ratio_valid,
    output logic             div_err,
    output logic             busy
`ifdef PPG_PERFUSION_GATE_EN
    ,
    output logic             low_perf
`endif
);
    localparam int NUM_W = num_w(FRAC);
    localparam int SUM_W = ADC_W + WIN_LOG2;
    localparam int CNT_W = WIN_LOG2 + 1;
    localparam logic [CNT_W-1:0] WIN = {1'b1, {WIN_LOG2{1'b0}}};

    state_t state_q, state_d;
    // index 1 = RED, index 0 = IR
    logic [1:0][ADC_W-1:0] max_q, max_d, min_q, min_d;
    logic [1:0][SUM_W-1:0] sum_q, sum_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [ADC_W-1:0] ac_red_q, ac_red_d, ac_ir_q, ac_ir_d, dc_red_q, dc_red_d, dc_ir_q, dc_ir_d;
    logic [ADC_W-1:0] r_q, r_d, r_new;
    logic             err_q, err_d, err_new;
    logic [ADC_W-1:0] ac_r, ac_i, dc_r, dc_i;
    logic [PROD_W-1:0] num, den;
    logic             load, clr, gate, div_start, div_done, div_dbz;
    logic [NUM_W-1:0] quot;

`ifdef PPG_PERFUSION_GATE_EN
    logic lp_q, lp_d;
    assign gate = (ac_r < ADC_W'(MIN_AC)) || (ac_i < ADC_W'(MIN_AC));
    assign lp_d = load ? gate : lp_q;
    assign low_perf = lp_q;
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) lp_q <= 1'b0;
        else        lp_q <= lp_d;
    end
`else
    logic unused_min_ac;
    assign gate = 1'b0;
    assign unused_min_ac = |ADC_W'(MIN_AC);
`endif

    assign ac_r = max_q[1] - min_q[1];
    assign ac_i = max_q[0] - min_q[0];
    assign dc_r = sum_q[1][WIN_LOG2 +: ADC_W];
    assign dc_i = sum_q[0][WIN_LOG2 +: ADC_W];
    assign num  = PROD_W'(ac_r) * PROD_W'(dc_i);
    assign den  = PROD_W'(ac_i) * PROD_W'(dc_red_src());

    function automatic logic [ADC_W-1:0] dc_red_src();
        return dc_r;
    endfunction

    seq_divider #(.NUM_W(NUM_W), .DEN_W(PROD_W)) u_div (
        .CLK   (CLK),
        .rst_n (rst_n),
        .clr   (!enable),
        .start (div_start),
        .num   ({num, {FRAC{1'b0}}}),
        .den   (den),
        .done  (div_done),
        .quot  (quot),
        .dbz   (div_dbz)
    );

    always_comb begin
        state_d   = state_q;
        max_d     = max_q;
        min_d     = min_q;
        sum_d     = sum_q;
        cnt_d     = cnt_q;
        ac_red_d  = ac_red_q;
        ac_ir_d   = ac_ir_q;
        dc_red_d  = dc_red_q;
        dc_ir_d   = dc_ir_q;
        r_d       = r_q;
        err_d     = err_q;
        r_new     = r_q;
        err_new   = 1'b0;
        load      = 1'b0;
        clr       = 1'b0;
        div_start = 1'b0;
        case (state_q)
            IDLE: state_d = ACCUM;
            ACCUM: begin
                if (sample_valid && cnt_q[sample_is_red] != WIN) begin
                    max_d[sample_is_red] = sample_data > max_q[sample_is_red] ? sample_data : max_q[sample_is_red];
                    min_d[sample_is_red] = sample_data < min_q[sample_is_red] ? sample_data : min_q[sample_is_red];
                    sum_d[sample_is_red] = sum_q[sample_is_red] + SUM_W'(sample_data);
                    cnt_d[sample_is_red] = cnt_q[sample_is_red] + CNT_W'(1);
                end
                if (cnt_q[0] == WIN && cnt_q[1] == WIN) state_d = MULT;
            end
            MULT: begin
                // low perfusion and zero denominator both bypass the divider
                if (gate || div_dbz) begin
                    load    = 1'b1;
                    state_d = DONE;
                    r_new   = gate ? r_q : '1;
                    err_new = !gate;
                end else begin
                    div_start = 1'b1;
                    state_d   = DIVIDE;
                end
            end
            DIVIDE: begin
                if (div_done) begin
                    load    = 1'b1;
                    state_d = DONE;
                    r_new   = quot > NUM_W'(255) ? '1 : quot[ADC_W-1:0];
                end
            end
            DONE: begin
                clr     = 1'b1;
                state_d = ACCUM;
            end
            default: state_d = IDLE;
        endcase
        if (!enable) begin
            state_d = IDLE;
            load    = 1'b0;
            clr     = 1'b1;
        end
        if (clr) begin
            max_d = '0;
            min_d = '1;
            sum_d = '0;
            cnt_d = '0;
        end
        if (load) begin
            ac_red_d = ac_r;
            ac_ir_d  = ac_i;
            dc_red_d = dc_r;
            dc_ir_d  = dc_i;
            r_d      = r_new;
            err_d    = err_new;
        end
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            max_q    <= '0;
            min_q    <= '1;
            sum_q    <= '0;
            cnt_q    <= '0;
            ac_red_q <= '0;
            ac_ir_q  <= '0;
            dc_red_q <= '0;
            dc_ir_q  <= '0;
            r_q      <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            max_q    <= max_d;
            min_q    <= min_d;
            sum_q    <= sum_d;
            cnt_q    <= cnt_d;
            ac_red_q <= ac_red_d;
            ac_ir_q  <= ac_ir_d;
            dc_red_q <= dc_red_d;
            dc_ir_q  <= dc_ir_d;
            r_q      <= r_d;
            err_q    <= err_d;
        end
    end

    assign AC_RED      = ac_red_q;
    assign AC_IR       = ac_ir_q;
    assign DC_RED      = dc_red_q;
    assign DC_IR       = dc_ir_q;
    assign R_ratio     = r_q;
    assign div_err     = err_q;
    assign ratio_valid = (state_q == DONE);
    assign busy        = (state_q == MULT) || (state_q == DIVIDE) || (state_q == DONE);
endmodule

// File: tb/tb_spo2_ratio_unit.sv
// tb_spo2_ratio_unit: directed stimulus against a queue-based window model plus literal result checks
module tb_spo2_ratio_unit;
    localparam int WIN    = 32;
    localparam int FRAC   = 6;
    localparam int MIN_AC = 4;
    localparam int NUM_W  = 16 + FRAC;

    logic       CLK = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       sample_valid = 1'b0;
    logic       sample_is_red = 1'b0;
    logic [7:0] sample_data = 8'd0;
    logic [7:0] AC_RED, AC_IR, DC_RED, DC_IR, R_ratio;
    logic       ratio_valid, div_err, busy;
`ifdef PPG_PERFUSION_GATE_EN
    logic       low_perf;
`endif

    spo2_ratio_unit dut (
        .CLK           (CLK),
        .rst_n         (rst_n),
        .enable        (enable),
        .sample_valid  (sample_valid),
        .sample_is_red (sample_is_red),
        .sample_data   (sample_data),
        .AC_RED        (AC_RED),
        .AC_IR         (AC_IR),
        .DC_RED        (DC_RED),
        .DC_IR         (DC_IR),
        .R_ratio       (R_ratio),
        .ratio_valid   (ratio_valid),
        .div_err       (div_err),
        .busy          (busy)
`ifdef PPG_PERFUSION_GATE_EN
        ,
        .low_perf      (low_perf)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_edge = 0;
    int pulses = 0;

    always @(posedge CLK) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Spec-level model: collect accepted samples per channel, derive the result when both windows fill,
    // and release it after the documented latency unless enable drops first.
    int red_q[$], ir_q[$];
    int phase = 0;   // 0 idle, 1 collecting, 2 computing, 3 result cycle
    int elapsed = 0, lat = 0;
    int m_valid = 0, m_acr = 0, m_aci = 0, m_dcr = 0, m_dci = 0, m_r = 0, m_err = 0, m_lp = 0;
    int p_acr, p_aci, p_dcr, p_dci, p_r, p_err, p_lp;

    function automatic void win_stats(input int q[$], output int ac, output int dc);
        int mx = 0, mn = 255, s = 0;
        foreach (q[i]) begin
            mx = q[i] > mx ? q[i] : mx;
            mn = q[i] < mn ? q[i] : mn;
            s += q[i];
        end
        ac = mx - mn;
        dc = s / WIN;
    endfunction

    function automatic void compute();
        longint q;
        int num, den;
        win_stats(red_q, p_acr, p_dcr);
        win_stats(ir_q, p_aci, p_dci);
        num = p_acr * p_dci;
        den = p_aci * p_dcr;
        p_err = 0;
        p_lp = 0;
        lat = 2;
`ifdef PPG_PERFUSION_GATE_EN
        if (p_acr < MIN_AC || p_aci < MIN_AC) begin
            p_r = m_r;
            p_lp = 1;
            return;
        end
`endif
        if (den == 0) begin
            p_r = 255;
            p_err = 1;
        end else begin
            q = (longint'(num) << FRAC) / den;
            p_r = q > 255 ? 255 : int'(q);
            lat = 2 + NUM_W;
        end
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            phase = 0;
            red_q.delete();
            ir_q.delete();
            {m_valid, m_acr, m_aci, m_dcr, m_dci, m_r, m_err, m_lp} = '0;
        end else begin
            m_valid = 0;
            if (!enable) begin
                phase = 0;
                red_q.delete();
                ir_q.delete();
            end else if (phase == 0) begin
                phase = 1;
            end else if (phase == 1) begin
                if (sample_valid && sample_is_red && red_q.size() < WIN) red_q.push_back(int'(sample_data));
                else if (sample_valid && !sample_is_red && ir_q.size() < WIN) ir_q.push_back(int'(sample_data));
                if (red_q.size() == WIN && ir_q.size() == WIN) begin
                    compute();
                    phase = 2;
                    elapsed = 0;
                end
            end else if (phase == 2) begin
                elapsed++;
                if (elapsed == lat) begin
                    {m_acr, m_aci, m_dcr, m_dci, m_r, m_err, m_lp} = {p_acr, p_aci, p_dcr, p_dci, p_r, p_err, p_lp};
                    m_valid = 1;
                    phase = 3;
                end
            end else begin
                phase = 1;
                red_q.delete();
                ir_q.delete();
            end
        end
    end

    always @(negedge CLK) begin
        if (ratio_valid) pulses++;
        chk("ratio_valid", int'(ratio_valid), m_valid);
        chk("busy", int'(busy), int'((phase == 2 && elapsed >= 1) || phase == 3));
        chk("AC_RED", int'(AC_RED), m_acr);
        chk("AC_IR", int'(AC_IR), m_aci);
        chk("DC_RED", int'(DC_RED), m_dcr);
        chk("DC_IR", int'(DC_IR), m_dci);
        chk("R_ratio", int'(R_ratio), m_r);
        chk("div_err", int'(div_err), m_err);
`ifdef PPG_PERFUSION_GATE_EN
        chk("low_perf", int'(low_perf), m_lp);
`endif
    end

    task automatic send(input bit red, input int d);
        sample_valid = 1'b1;
        sample_is_red = red;
        sample_data = 8'(d);
        @(posedge CLK);
        #1;
        last_edge = cyc;
        sample_valid = 1'b0;
    endtask

    task automatic window(input int ra, input int rb, input int ia, input int ib);
        for (int i = 0; i < WIN; i++) begin
            send(1'b1, (i % 2) ? rb : ra);
            send(1'b0, (i % 2) ? ib : ia);
        end
    endtask

    task automatic result(input string name, input int acr, input int dcr, input int aci, input int dci,
                          input int r, input int err, input int exp_lat, input int lp);
        int l = -1;
        for (int n = 0; n < 100 && l < 0; n++) begin
            @(negedge CLK);
            if (ratio_valid) l = cyc - last_edge;
        end
        chk({name, " latency"}, l, exp_lat);
        chk({name, " AC_RED"}, int'(AC_RED), acr);
        chk({name, " DC_RED"}, int'(DC_RED), dcr);
        chk({name, " AC_IR"}, int'(AC_IR), aci);
        chk({name, " DC_IR"}, int'(DC_IR), dci);
        chk({name, " R_ratio"}, int'(R_ratio), r);
        chk({name, " div_err"}, int'(div_err), err);
`ifdef PPG_PERFUSION_GATE_EN
        chk({name, " low_perf"}, int'(low_perf), lp);
`else
        if (lp != 0) chk({name, " low_perf unsupported"}, lp, 0);
`endif
        @(posedge CLK);
        #1;
    endtask

    initial begin
        int base;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset R_ratio", int'(R_ratio), 0);
        chk("reset AC_RED", int'(AC_RED), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset ratio_valid", int'(ratio_valid), 0);
        rst_n = 1'b1;
        enable = 1'b1;
        @(posedge CLK);
        #1;
        window(100, 140, 110, 130);
        result("r2", 40, 120, 20, 120, 128, 0, 24, 0);
        window(110, 130, 110, 130);
        result("r1", 20, 120, 20, 120, 64, 0, 24, 0);
        window(20, 220, 110, 130);
        result("sat", 200, 120, 20, 120, 255, 0, 24, 0);
        for (int i = 0; i < 40; i++) send(1'b1, i < WIN ? ((i % 2) ? 140 : 100) : ((i % 2) ? 255 : 0));
        for (int i = 0; i < WIN; i++) send(1'b0, (i % 2) ? 130 : 110);
        result("extra_red", 40, 120, 20, 120, 128, 0, 24, 0);
        window(100, 140, 120, 120);
`ifdef PPG_PERFUSION_GATE_EN
        result("den0", 40, 120, 0, 120, 128, 0, 2, 1);
`else
        result("den0", 40, 120, 0, 120, 255, 1, 2, 0);
`endif
        base = pulses;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 200);
            send(1'b0, 10);
        end
        enable = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        enable = 1'b1;
        @(posedge CLK);
        #1;
        window(100, 140, 110, 130);
        result("abort", 40, 120, 20, 120, 128, 0, 24, 0);
        chk("abort pulses", pulses - base, 1);
`ifdef PPG_PERFUSION_GATE_EN
        window(100, 140, 119, 121);
        result("lowperf", 40, 120, 2, 120, 128, 0, 2, 1);
`endif
        window(100, 140, 110, 130);
        repeat (6) @(negedge CLK);
        chk("mid busy", int'(busy), 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst AC_RED", int'(AC_RED), 0);
        chk("rst R_ratio", int'(R_ratio), 0);
        chk("rst div_err", int'(div_err), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst ratio_valid", int'(ratio_valid), 0);
        @(posedge CLK);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
